// File: rtl/count_chk_pkg.sv
// Shared types and helpers for the count sequence checker: FSM state encoding,
// direction constants and the modular step used to predict the next count.
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQ     = 2'd1,
        LOCKING = 2'd2,
        LOCKED  = 2'd3
    } chk_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // All-ones mask for a bus of the given width (widths up to 32 bits).
    function automatic logic [31:0] width_mask(input int width);
        logic [31:0] mask;
        if (width >= 32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return mask;
    endfunction

    // Next value of a free-running counter of the given width and direction.
    function automatic logic [31:0] count_step(input logic [31:0] x, input int width,
                                               input logic dir);
        logic [31:0] nxt;
        if (dir == DIR_DOWN) begin
            nxt = x - 32'd1;
        end else begin
            nxt = x + 32'd1;
        end
        return nxt & width_mask(width);
    endfunction

    // Value reached by a correct wrap-around: 0 counting up, all-ones counting down.
    function automatic logic [31:0] wrap_value(input int width, input logic dir);
        logic [31:0] v;
        if (dir == DIR_DOWN) begin
            v = width_mask(width);
        end else begin
            v = 32'd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear; optionally saturates at all-ones,
// otherwise rolls over. An increment in the clear cycle leaves the count at 1.
module sat_counter
    import count_chk_pkg::*;
#(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic at_max;

    assign at_max = SAT && (count == MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running counter bus: locks onto the +/-1 sequence, flags
// skips/stalls/reversals once locked, and counts errors and wrap-arounds.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8,
    parameter int DIR      = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  count_in,
    output logic              locked,
    output logic              err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]  expected
);

    localparam logic             DIR_BIT   = (DIR != 0) ? DIR_DOWN : DIR_UP;
    localparam int               MW        = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WIDTH-1:0] WRAP_AT   = WIDTH'(wrap_value(WIDTH, DIR_BIT));

    if (LOCK_CNT < 1) begin : g_bad_lock_cnt
        $error("count_seq_checker: LOCK_CNT must be at least 1");
    end

    function automatic logic [WIDTH-1:0] next_of(input logic [WIDTH-1:0] x);
        return WIDTH'(count_step(32'(x), WIDTH, DIR_BIT));
    endfunction

    chk_state_e       state;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] expected_q;
    logic [MW-1:0]    match_cnt;
    logic             err_q;
    logic             sticky_q;
    logic             hit;
    logic             err_ev;
    logic             wrap_ev;

    // Input stage: the registered sample is the only thing the checker ever compares.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q <= '0;
        end else begin
            s_q <= count_in;
        end
    end

    assign hit     = (s_q == expected_q);
    assign err_ev  = en && (state == LOCKED) && !hit;
    assign wrap_ev = en && (state == LOCKED) && hit && (s_q == WRAP_AT);

    // After any miss the prediction restarts from the observed sample, so a
    // single skip costs one error and a short relock rather than a cascade.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            expected_q <= '0;
            match_cnt  <= '0;
        end else if (!en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state <= ACQ;
                end
                ACQ: begin
                    expected_q <= next_of(s_q);
                    match_cnt  <= '0;
                    state      <= LOCKING;
                end
                LOCKING: begin
                    if (hit) begin
                        expected_q <= next_of(expected_q);
                        match_cnt  <= match_cnt + MW'(1);
                        if (match_cnt == LOCK_LAST) begin
                            state <= LOCKED;
                        end
                    end else begin
                        expected_q <= next_of(s_q);
                        match_cnt  <= '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        expected_q <= next_of(expected_q);
                    end else begin
                        expected_q <= next_of(s_q);
                        match_cnt  <= '0;
                        state      <= LOCKING;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            err_q <= err_ev;
            if (err_ev) begin
                sticky_q <= 1'b1;
            end else if (clr) begin
                sticky_q <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W   (ERR_W),
        .SAT (1'b1)
    ) u_err_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .inc   (err_ev),
        .count (err_cnt)
    );

    sat_counter #(
        .W   (WRAP_W),
        .SAT (1'b0)
    ) u_wrap_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .inc   (wrap_ev),
        .count (wrap_cnt)
    );

    assign locked     = (state == LOCKED);
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomised bench for count_seq_checker: four configurations share one stimulus
// stream and are compared every cycle against a sample-history reference model.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       clr;
    logic [2:0] count_in;

    logic       lk0, er0, st0;
    logic [7:0] ec0, wc0;
    logic [2:0] ex0;
    logic       lk1, er1, st1;
    logic [1:0] ec1;
    logic [7:0] wc1;
    logic [2:0] ex1;
    logic       lk2, er2, st2;
    logic [7:0] ec2, wc2;
    logic [2:0] ex2;
    logic       lk3, er3, st3;
    logic [7:0] ec3, wc3;
    logic [0:0] ex3;

    always #5 clk = ~clk;

    // d0: defaults, d1: ERR_W=2, d2: down counter, d3: WIDTH=1 with LOCK_CNT=1
    count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .ERR_W(8), .WRAP_W(8), .DIR(0)) d0 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .count_in(count_in),
        .locked(lk0), .err(er0), .err_sticky(st0), .err_cnt(ec0), .wrap_cnt(wc0), .expected(ex0));
    count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .ERR_W(2), .WRAP_W(8), .DIR(0)) d1 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .count_in(count_in),
        .locked(lk1), .err(er1), .err_sticky(st1), .err_cnt(ec1), .wrap_cnt(wc1), .expected(ex1));
    count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .ERR_W(8), .WRAP_W(8), .DIR(1)) d2 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .count_in(count_in),
        .locked(lk2), .err(er2), .err_sticky(st2), .err_cnt(ec2), .wrap_cnt(wc2), .expected(ex2));
    count_seq_checker #(.WIDTH(1), .LOCK_CNT(1), .ERR_W(8), .WRAP_W(8), .DIR(0)) d3 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .count_in(count_in[0:0]),
        .locked(lk3), .err(er3), .err_sticky(st3), .err_cnt(ec3), .wrap_cnt(wc3), .expected(ex3));

    localparam int CW[4] = '{3, 3, 3, 1};
    localparam int CD[4] = '{0, 0, 1, 0};
    localparam int CL[4] = '{2, 2, 2, 1};
    localparam int CE[4] = '{255, 3, 255, 255};

    int vectors = 0;
    int miscompares = 0;
    int cnt = 0;

    // Reference model. Once acquisition is done, every sample is judged against
    // step(previous sample); 'run' is the number of consecutive good steps, and the
    // checker counts as locked while run >= LOCK_CNT. Phase: 0 off, 1 first enabled
    // edge, 2 first sample taken as reference, 3 tracking.
    int ph[4], prev[4], pred[4], run[4], ecm[4], wcm[4];
    bit erm[4], stm[4];

    function automatic int mask_of(input int i);
        return (1 << CW[i]) - 1;
    endfunction

    function automatic int stp(input int i, input int x);
        return (CD[i] != 0) ? ((x - 1) & mask_of(i)) : ((x + 1) & mask_of(i));
    endfunction

    function automatic bit m_locked(input int i);
        return (ph[i] == 3) && (run[i] >= CL[i]);
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            ph[i] = 0; prev[i] = 0; pred[i] = 0; run[i] = 0;
            ecm[i] = 0; wcm[i] = 0; erm[i] = 0; stm[i] = 0;
        end
        forever begin : model
            int c;
            bit e, w, was;
            @(posedge clk or negedge rstn);
            for (int i = 0; i < 4; i++) begin
                if (!rstn) begin
                    ph[i] = 0; prev[i] = 0; pred[i] = 0; run[i] = 0;
                    ecm[i] = 0; wcm[i] = 0; erm[i] = 0; stm[i] = 0;
                end else begin
                    c = int'(count_in) & mask_of(i);
                    e = 0;
                    w = 0;
                    if (!en) begin
                        ph[i] = 0;
                    end else if (ph[i] == 0) begin
                        ph[i] = 1;
                    end else if (ph[i] == 1) begin
                        pred[i] = stp(i, prev[i]);
                        run[i] = 0;
                        ph[i] = 3;
                    end else begin
                        was = run[i] >= CL[i];
                        if (prev[i] == pred[i]) begin
                            if (was && prev[i] == ((CD[i] != 0) ? mask_of(i) : 0)) w = 1;
                            if (!was) run[i]++;
                        end else begin
                            if (was) e = 1;
                            run[i] = 0;
                        end
                        pred[i] = stp(i, prev[i]);
                    end
                    erm[i] = e;
                    if (clr) ecm[i] = e ? 1 : 0;
                    else if (e && ecm[i] < CE[i]) ecm[i]++;
                    if (clr) wcm[i] = w ? 1 : 0;
                    else if (w) wcm[i] = (wcm[i] + 1) % 256;
                    if (e) stm[i] = 1;
                    else if (clr) stm[i] = 0;
                    prev[i] = c;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input int req);
        logic [31:0] r;
        r = req;
        vectors++;
        if (act !== r) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, r, $time);
        end
    endtask

    task automatic cmp(input int i, input logic lk, input logic er, input logic st,
                       input logic [31:0] ec, input logic [31:0] wc, input logic [31:0] ex);
        check($sformatf("d%0d.locked", i), {31'b0, lk}, int'(m_locked(i)));
        check($sformatf("d%0d.err", i), {31'b0, er}, int'(erm[i]));
        check($sformatf("d%0d.err_sticky", i), {31'b0, st}, int'(stm[i]));
        check($sformatf("d%0d.err_cnt", i), ec, ecm[i]);
        check($sformatf("d%0d.wrap_cnt", i), wc, wcm[i]);
        check($sformatf("d%0d.expected", i), ex, pred[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, lk0, er0, st0, 32'(ec0), 32'(wc0), 32'(ex0));
            cmp(1, lk1, er1, st1, 32'(ec1), 32'(wc1), 32'(ex1));
            cmp(2, lk2, er2, st2, 32'(ec2), 32'(wc2), 32'(ex2));
            cmp(3, lk3, er3, st3, 32'(ec3), 32'(wc3), 32'(ex3));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int v, input bit e, input bit c);
        count_in = v[2:0];
        en = e;
        clr = c;
        @(negedge clk);
    endtask

    task automatic up(input int n, input bit c = 1'b0);
        for (int k = 0; k < n; k++) begin
            drive(cnt, 1'b1, (k == 0) ? c : 1'b0);
            cnt++;
        end
    endtask

    task automatic dn(input int n);
        for (int k = 0; k < n; k++) begin
            drive(cnt, 1'b1, 1'b0);
            cnt--;
        end
    endtask

    initial begin
        int r;
        bit go_down;
        rstn = 1'b0;
        en = 1'b1;
        clr = 1'b0;
        count_in = 3'd0;
        #1;
        check("rst.locked", {31'b0, lk0}, 0);
        check("rst.err_cnt", 32'(ec0), 0);
        check("rst.expected", 32'(ex0), 0);
        @(negedge clk);
        rstn = 1'b1;

        // ideal up counter: lock after 4 edges, 2 wraps in the following 16
        up(3);
        check("lock3.locked", {31'b0, lk0}, 0);
        up(1);
        check("lock4.locked", {31'b0, lk0}, 1);
        check("lock4.model", {31'b0, m_locked(0)}, 1);
        check("lock4.d2_unlocked", {31'b0, lk2}, 0);
        up(16);
        check("wrap16.wrap_cnt", 32'(wc0), 2);
        check("wrap16.model", 32'(wcm[0]), 2);

        // skip: 3 was last driven, now 5
        cnt++;
        up(1);
        up(1);
        check("skip.err", {31'b0, er0}, 1);
        check("skip.err_cnt", 32'(ec0), 1);
        check("skip.sticky", {31'b0, st0}, 1);
        check("skip.locked", {31'b0, lk0}, 0);
        up(1);
        check("skip.err_pulse", {31'b0, er0}, 0);
        up(1);
        check("relock.locked", {31'b0, lk0}, 1);
        check("relock.expected", 32'(ex0), 0);

        // stall at 4 for two clocks
        up(4);
        cnt--;
        up(1);
        up(1);
        check("stall.err", {31'b0, er0}, 1);
        up(1);
        check("stall.err_cnt", 32'(ec0), 2);
        up(5);

        // three more faults: d1 saturates at 3
        for (int f = 0; f < 3; f++) begin
            cnt++;
            up(1);
            up(5);
        end
        check("sat.d1_err_cnt", 32'(ec1), 3);
        check("sat.d0_err_cnt", 32'(ec0), 5);

        // sixth fault in the same cycle as clr
        cnt++;
        up(1);
        up(1, 1'b1);
        check("clr.d1_err_cnt", 32'(ec1), 1);
        check("clr.d0_err_cnt", 32'(ec0), 1);
        check("clr.sticky", {31'b0, st0}, 1);
        up(5);

        // down counter: d2 locks, d0 errs once then never relocks
        dn(20);
        check("down.d2_locked", {31'b0, lk2}, 1);
        check("down.d0_locked", {31'b0, lk0}, 0);
        check("down.d2_err_cnt", 32'(ec2), 0);

        // asynchronous reset between edges
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst.d2_locked", {31'b0, lk2}, 0);
        check("arst.d2_wrap_cnt", 32'(wc2), 0);
        check("arst.d0_err_cnt", 32'(ec0), 0);
        check("arst.d0_sticky", {31'b0, st0}, 0);
        check("arst.d2_expected", 32'(ex2), 0);
        @(negedge clk);
        rstn = 1'b1;
        dn(3);
        check("arst.relock3", {31'b0, lk2}, 0);
        dn(1);
        check("arst.relock4", {31'b0, lk2}, 1);
        check("arst.d2_err_cnt", 32'(ec2), 0);

        // randomised traffic: steps, stalls, jumps, reversals, enable drops, clears
        go_down = 1'b0;
        for (int k = 0; k < 800; k++) begin
            r = int'($urandom_range(0, 31));
            if (r == 1) cnt = int'($urandom_range(0, 7));
            else if (r == 3) go_down = ~go_down;
            else if (r != 2) cnt = go_down ? cnt - 1 : cnt + 1;
            drive(cnt, (r != 0), (r == 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Receive-side monitor for the free-running T-flip-flop counters in this design. It samples a counter's count bus every clock and checks that the value advances by exactly one, modulo 2^WIDTH, in the configured direction. It locks onto the sequence, flags skips and stalls, and counts wrap-arounds. It sits beside the counter in the lab top level and feeds LEDs and the test benches.

Parameters:
WIDTH, 3, width of the monitored count bus.
LOCK_CNT, 2, consecutive correct steps required to declare lock (must be at least 1).
ERR_W, 8, width of the saturating error counter.
WRAP_W, 8, width of the wrap counter, which rolls over naturally.
DIR, 0, expected direction: 0 = up (+1), 1 = down (-1).

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
en  input  1  enable checking; 0 forces the IDLE state.
clr  input  1  synchronous one-cycle pulse that clears err_cnt, wrap_cnt and err_sticky.
count_in  input  WIDTH  count bus from the counter under check.
locked  output  1  high while in the LOCKED state.
err  output  1  one-cycle pulse for each sequence violation detected while locked.
err_sticky  output  1  set on any err; cleared only by clr or reset.
err_cnt  output  ERR_W  saturating count of err pulses.
wrap_cnt  output  WRAP_W  number of correct wrap transitions seen while locked.
expected  output  WIDTH  next value the checker expects.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; s_q=0; expected=0; match_cnt=0; all outputs 0.
- Input stage:
  - s_q <= count_in every clock, in every state; this is the only use of count_in.
  - Sequence latency is therefore 1 cycle: err asserts the clock after the bad sample edge.
- step(x) = x+1 mod 2^WIDTH when DIR=0; x-1 mod 2^WIDTH when DIR=1.
- State IDLE:
  - locked=0; expected holds.
  - en=1 -> ACQ.
- State ACQ (one cycle):
  - expected <= step(s_q); match_cnt <= 0 -> LOCKING.
- State LOCKING:
  - On match (s_q==expected): expected <= step(expected); match_cnt++. If match_cnt==LOCK_CNT-1 -> LOCKED.
  - On mismatch: expected <= step(s_q); match_cnt <= 0; stay in LOCKING. No err is raised.
- State LOCKED:
  - locked=1.
  - On match: expected <= step(expected).
  - Match with s_q==0 (DIR=0) or s_q==2^WIDTH-1 (DIR=1) counts as a wrap: wrap_cnt++.
  - On mismatch (skip, stall or reverse): err=1 for one cycle; err_sticky <= 1; err_cnt++ saturating at 2^ERR_W-1; expected <= step(s_q); match_cnt <= 0 -> LOCKING.
- en=0 in any state -> IDLE on the next edge; no err is raised. err_cnt, wrap_cnt and err_sticky hold.
- clr:
  - Clears err_cnt, wrap_cnt and err_sticky.
  - If an err or wrap event occurs in the same cycle, the event wins: the counter becomes 1 and err_sticky becomes 1.
- WIDTH=1: the sequence 0,1,0,1 is valid; every return to 0 is a wrap.
- A mid-operation reset returns to IDLE immediately, without waiting for a clock edge. The first post-reset sample is not checked.

Decomposition:
- Package count_chk_pkg holds:
  - state enum IDLE/ACQ/LOCKING/LOCKED;
  - the DIR_UP/DIR_DOWN constants;
  - a step function parameterised on WIDTH.
- One sub-module, sat_counter (parameterised width, saturate enable), is used for err_cnt and for wrap_cnt with saturation off.
- FSM and compare logic stay in the top module.

Test Plan:
1. rstn low 10 ns, then high with en=1; ideal up counter 0..7 -> locked rises 1+1+LOCK_CNT=4 clocks after rstn rises; err never asserts; wrap_cnt=2 after 16 further clocks.
2. While locked, force count_in 3 -> 5 (skip 4) -> err high exactly 1 cycle; err_cnt=1; err_sticky=1; locked low; relock after 2 clean steps (6, 7) with expected=0.
3. While locked, hold count_in at 4 for two clocks (stall) -> one err pulse; err_cnt increments by 1, not 2.
4. ERR_W=2, inject 5 separate faults -> err_cnt saturates at 3. Then pulse clr in the same cycle as a 6th fault -> err_cnt=1, err_sticky=1.
5. DIR=1 with a down counter 7,6,..,0,7 -> lock; wrap_cnt increments on each 0->7; the same counter in DIR=0 never locks and raises no err.
6. Assert rstn=0 mid-count, between clock edges -> all outputs 0 before the next edge. Release -> relock in 4 clocks, with err_cnt not incremented by the discontinuity.
